// File: rtl/operand_fetch.sv
// Operand fetch: drives both register-file read ports, tracks pending writes in a
// scoreboard and registers operands for execute. Optional macro: OPERAND_FORWARDING_EN.
module operand_fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] rs1_index,
  input  logic [DEPTH-1:0] rs2_index,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [DEPTH-1:0] rd_index,
  input  logic             rd_write,
  output logic             read_enable_1,
  output logic             read_enable_2,
  output logic [DEPTH-1:0] read_index_1,
  output logic [DEPTH-1:0] read_index_2,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic             wb_valid,
  input  logic [DEPTH-1:0] wb_index,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rs1_data,
  output logic [WIDTH-1:0] out_rs2_data,
  output logic [DEPTH-1:0] out_rd_index,
  output logic             out_rd_write,
  output logic             busy
);

  localparam int NUM_REGS = 1 << DEPTH;
  localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] NO_BITS   = {NUM_REGS{1'b0}};
  localparam logic [DEPTH-1:0]    REG_ZERO  = {DEPTH{1'b0}};

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_next_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic                busy_r;
  logic                fwd_1_s;
  logic                fwd_2_s;
  logic                hazard_s;
  logic                accept_s;
  logic [WIDTH-1:0]    operand_1_s;
  logic [WIDTH-1:0]    operand_2_s;

  assign read_enable_1 = in_valid && rs1_used;
  assign read_enable_2 = in_valid && rs2_used;
  assign read_index_1  = rs1_index;
  assign read_index_2  = rs2_index;

`ifdef OPERAND_FORWARDING_EN
  assign fwd_1_s = rs1_used && wb_valid && (wb_index == rs1_index) && (rs1_index != REG_ZERO);
  assign fwd_2_s = rs2_used && wb_valid && (wb_index == rs2_index) && (rs2_index != REG_ZERO);
`else
  assign fwd_1_s = 1'b0;
  assign fwd_2_s = 1'b0;
`endif

  // WAW checks the pending bit alone: a destination is never released by forwarding
  assign hazard_s = in_valid &&
                    ((rs1_used && pend_r[rs1_index] && !fwd_1_s) ||
                     (rs2_used && pend_r[rs2_index] && !fwd_2_s) ||
                     (rd_write && (rd_index != REG_ZERO) && pend_r[rd_index]));
  assign in_ready = !hazard_s && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;

  // Set after clear so an accept claiming the register being written back stays pending
  assign clr_mask_s  = wb_valid ? (ONE_HOT_0 << wb_index) : NO_BITS;
  assign set_mask_s  = (accept_s && rd_write) ? (ONE_HOT_0 << rd_index) : NO_BITS;
  assign pend_next_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;

  // Operand select: forwarded writeback, register file data, or zero when unused
  always_comb begin
    operand_1_s = {WIDTH{1'b0}};
    operand_2_s = {WIDTH{1'b0}};
    if (fwd_1_s) begin
      operand_1_s = wb_data;
    end else if (rs1_used) begin
      operand_1_s = read_data_1;
    end else begin
      operand_1_s = {WIDTH{1'b0}};
    end
    if (fwd_2_s) begin
      operand_2_s = wb_data;
    end else if (rs2_used) begin
      operand_2_s = read_data_2;
    end else begin
      operand_2_s = {WIDTH{1'b0}};
    end
  end

  // Scoreboard and registered busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= NO_BITS;
      busy_r <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      busy_r <= |pend_next_s;
    end
  end

  assign busy = busy_r;

  // One-entry output register toward execute
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_rs1_data <= {WIDTH{1'b0}};
      out_rs2_data <= {WIDTH{1'b0}};
      out_rd_index <= REG_ZERO;
      out_rd_write <= 1'b0;
    end else if (accept_s) begin
      out_valid    <= 1'b1;
      out_rs1_data <= operand_1_s;
      out_rs2_data <= operand_2_s;
      out_rd_index <= rd_index;
      out_rd_write <= rd_write;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side requester for the dual-read, single-write register file. It accepts decoded instructions over a valid/ready handshake and drives both register-file read ports. A pending-write scoreboard protects against RAW and WAW hazards, with optional same-cycle writeback forwarding. Fetched operands go to the execute stage through a one-entry output register. It sits between decode and execute and is the only master of the register-file read ports.

## Interface
- WIDTH, 32, data width; matches register file WIDTH
- DEPTH, 5, register index width; 2^DEPTH architectural registers
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- rs1_index, rs2_index  in  DEPTH  source register indices
- rs1_used, rs2_used  in  1  source operand required
- rd_index  in  DEPTH  destination register index
- rd_write  in  1  instruction will write rd
- read_enable_1, read_enable_2  out  1  register file read enables
- read_index_1, read_index_2  out  DEPTH  register file read indices
- read_data_1, read_data_2  in  WIDTH  register file read data (combinational)
- wb_valid  in  1  writeback this cycle; the register file is written at the same edge
- wb_index  in  DEPTH  writeback register index
- wb_data  in  WIDTH  writeback data
- out_valid  out  1  operands valid toward execute
- out_ready  in  1  execute consumes when out_valid && out_ready
- out_rs1_data, out_rs2_data  out  WIDTH  fetched operands
- out_rd_index  out  DEPTH  registered rd_index
- out_rd_write  out  1  registered rd_write
- busy  out  1  any scoreboard bit set

## Operation
- Read ports: read_enable_1 = in_valid && rs1_used and read_index_1 = rs1_index. Port 2 is identical. Both are combinational.
- Scoreboard: 2^DEPTH pending bits. Bit 0 is permanently 0 and register 0 is never pending.
- Hazard (stall) when in_valid and any of:
  - rs1_used and pend[rs1_index], and the operand is not forwardable;
  - the same condition for rs2;
  - rd_write and rd_index != 0 and pend[rd_index] (WAW; never forwarded).
- in_ready = !hazard && (!out_valid || out_ready).
- Accept captures the output register:
  - operand = forwarded value if forwardable; else read_data if used; else 0;
  - out_rd_index and out_rd_write captured;
  - pend[rd_index] set if rd_write and rd_index != 0.
- Writeback: wb_valid clears pend[wb_index] at the edge. If an accept sets the same index at the same edge, set wins.
- Writeback to a non-pending register is legal: it updates data only.
- Output register holds all fields while out_valid && !out_ready.
- On consume with no new accept, out_valid falls; fields keep their last values.
- An operand with used=0 reads as 0, never Z.

## Timing
- Reset values: out_valid 0; out_rs1_data, out_rs2_data, out_rd_index, out_rd_write 0; all pend 0; busy 0.
- in_ready and read_* are combinational, so in_ready = 1 after reset.
- Latency: accept at edge N gives out_valid high in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and out_ready = 1.
- Back-to-back dependent instructions stall until the producer's writeback (see Configuration).
- Reset asserted mid-operation clears the output register and scoreboard immediately. In-flight writebacks after reset are treated as non-pending writes.

## Configuration
- OPERAND_FORWARDING_EN defined:
  - A source is forwardable when wb_valid && wb_index == source index && index != 0.
  - It takes wb_data and does not stall, even if pending.
- OPERAND_FORWARDING_EN undefined:
  - No forwarding; a pending source stalls in the writeback cycle.
  - The source is accepted the following cycle from read_data, after the bit clears and the register file is updated.
  - Adds one stall cycle per RAW hazard.

## Test plan
- Reset with in_valid = 0 -> out_valid = 0, busy = 0, in_ready = 1; release, then issue rs1 = 3 (reg 3 = 0x11), rs2 unused -> next cycle out_rs1_data = 0x11, out_rs2_data = 0.
- Issue rd = 5, rd_write = 1, then rs1 = 5 -> in_ready = 0 until wb_valid with wb_index = 5, wb_data = 0xABCD.
  - With OPERAND_FORWARDING_EN: accepted in the wb cycle, out_rs1_data = 0xABCD.
  - Without: accepted one cycle later with the same value.
- WAW: issue rd = 7 twice consecutively -> second held (in_ready = 0) until wb_index = 7, then accepted; pend[7] stays set afterward.
- rd = 0 with rd_write = 1, then rs1 = 0 -> no stall, busy stays 0, out_rs1_data = 0.
- out_ready = 0 for 3 cycles with an independent instruction waiting -> out fields stable, in_ready = 0; out_ready = 1 -> next instruction accepted that edge, out_valid stays 1.
- Assert reset while pend[4] is set and out_valid = 1 -> out_valid = 0 and busy = 0 immediately; after release, rs1 = 4 issues without stall.
